// File: rtl/cmd_initiator_if.sv
// cmd_initiator_if: command, payload, response and UART byte signals
// between a controller and the cmd_initiator block.
interface cmd_initiator_if;
   logic         txd_busy;
   logic         txd_start;
   logic [7:0]   txd_data;
   logic [7:0]   rxd_data;
   logic         rxd_data_ready;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [127:0] cmd_hash;
   logic [15:0]  cmd_num_bytes;
   logic [7:0]   src_data;
   logic         src_valid;
   logic         src_ready;
   logic         rsp_valid;
   logic         rsp_ack;
   logic         rsp_timeout;
   logic [15:0]  rsp_byte_pos;
   logic [7:0]   rsp_char;
   logic         rsp_char_valid;

   modport master (
      output txd_busy, rxd_data, rxd_data_ready,
      output cmd_valid, cmd_op, cmd_hash, cmd_num_bytes,
      output src_data, src_valid,
      input  txd_start, txd_data, cmd_ready, src_ready,
      input  rsp_valid, rsp_ack, rsp_timeout,
      input  rsp_byte_pos, rsp_char, rsp_char_valid
   );

   modport slave (
      input  txd_busy, rxd_data, rxd_data_ready,
      input  cmd_valid, cmd_op, cmd_hash, cmd_num_bytes,
      input  src_data, src_valid,
      output txd_start, txd_data, cmd_ready, src_ready,
      output rsp_valid, rsp_ack, rsp_timeout,
      output rsp_byte_pos, rsp_char, rsp_char_valid
   );
endinterface

// File: rtl/cmd_initiator.sv
// cmd_initiator: serialises SET/PROC/RET commands to a UART and parses replies.
// Define CMD_INITIATOR_TIMEOUT_EN to enable the per-reply-byte timeout.
module cmd_initiator #(
   parameter int MATCH_LEN      = 19,
   parameter int TIMEOUT_CYCLES = 9_600_000
) (
   input  logic           clk_96mhz,
   input  logic           reset,
   cmd_initiator_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, SEND_OP, SEND_HASH, SEND_LEN, SEND_DATA,
      WAIT_ACK, RX_POS, RX_CHARS, DONE
   } state_t;

   localparam logic [1:0]  OP_SET    = 2'd1;
   localparam logic [1:0]  OP_PROC   = 2'd2;
   localparam logic [15:0] LAST_CHAR = 16'(MATCH_LEN - 1);

   if (MATCH_LEN < 1 || MATCH_LEN > 65536) begin : g_bad_match_len
      $error("MATCH_LEN out of range");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777216) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES out of range");
   end

   state_t         state, state_d;
   logic [1:0]     op_q;
   logic [127:0]   hash_q;
   logic [15:0]    num_q;
   logic [15:0]    cnt;
   logic           holdoff;
   logic           can_tx;
   logic           tx_go;
   logic [7:0]     tx_byte;
   logic           rx_v_q;
   logic [7:0]     rx_d_q;
   logic           txd_start_q;
   logic [7:0]     txd_data_q;
   logic           rsp_ack_q;
   logic [15:0]    pos_q;
   logic [7:0]     char_q;
   logic           char_v_q;
   logic           accept;
   logic           src_ready;
   logic           src_fire;
   logic           rx_wait;
   logic           tmo_hit;

   assign can_tx        = ~bus.txd_busy & ~holdoff;
   assign bus.cmd_ready = (state == IDLE) & ~reset;
   assign accept        = bus.cmd_valid & bus.cmd_ready;
   assign src_ready     = (state == SEND_DATA) & can_tx &
                          (cnt != num_q) & ~reset;
   assign src_fire      = src_ready & bus.src_valid;
   assign rx_wait       = (state == WAIT_ACK) | (state == RX_POS) |
                          (state == RX_CHARS);

`ifdef CMD_INITIATOR_TIMEOUT_EN
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
   logic [23:0] tmo_cnt;
   logic        rsp_tmo_q;

   // reload on entry to a reply state and on every accepted byte
   always_ff @(posedge clk_96mhz) begin
      if (reset || !rx_wait || rx_v_q) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 24'd1;
   end

   assign tmo_hit = rx_wait & ~rx_v_q & (tmo_cnt == TMO_LAST);

   // timeout flag lives until the next command is taken
   always_ff @(posedge clk_96mhz) begin
      if (reset)        rsp_tmo_q <= 1'b0;
      else if (accept)  rsp_tmo_q <= 1'b0;
      else if (tmo_hit) rsp_tmo_q <= 1'b1;
   end

   assign bus.rsp_timeout = rsp_tmo_q;
`else
   assign tmo_hit         = 1'b0;
   assign bus.rsp_timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge clk_96mhz) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // next state and the byte to launch this cycle
   always_comb begin
      state_d = state;
      tx_go   = 1'b0;
      tx_byte = 8'h00;
      unique case (state)
         IDLE: begin
            if (accept)
               state_d = (bus.cmd_op == 2'd0) ? DONE : SEND_OP;
         end
         SEND_OP: begin
            if (can_tx) begin
               tx_go   = 1'b1;
               tx_byte = {6'd0, op_q};
               if (op_q == OP_SET)       state_d = SEND_HASH;
               else if (op_q == OP_PROC) state_d = SEND_LEN;
               else                      state_d = RX_POS;
            end
         end
         SEND_HASH: begin
            if (can_tx) begin
               tx_go   = 1'b1;
               tx_byte = hash_q[127:120];
               if (cnt == 16'd15) state_d = WAIT_ACK;
            end
         end
         SEND_LEN: begin
            if (can_tx) begin
               tx_go   = 1'b1;
               tx_byte = (cnt == 16'd0) ? num_q[15:8] : num_q[7:0];
               if (cnt == 16'd1)
                  state_d = (num_q == 16'd0) ? WAIT_ACK : SEND_DATA;
            end
         end
         SEND_DATA: begin
            if (src_fire) begin
               tx_go   = 1'b1;
               tx_byte = bus.src_data;
               if (cnt == num_q - 16'd1) state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (rx_v_q || tmo_hit) state_d = DONE;
         end
         RX_POS: begin
            if (rx_v_q && cnt == 16'd1) state_d = RX_CHARS;
            else if (tmo_hit)           state_d = DONE;
         end
         RX_CHARS: begin
            if (rx_v_q && cnt == LAST_CHAR) state_d = DONE;
            else if (tmo_hit)               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // per-state byte counter, cleared on every state change
   always_ff @(posedge clk_96mhz) begin
      if (reset || state_d != state) cnt <= '0;
      else if (tx_go || (rx_wait && rx_v_q)) cnt <= cnt + 16'd1;
   end

   // tx launch register, rx capture, command latch and response fields
   always_ff @(posedge clk_96mhz) begin
      if (reset) begin
         txd_start_q <= 1'b0;
         txd_data_q  <= 8'h00;
         holdoff     <= 1'b0;
         rx_v_q      <= 1'b0;
         rx_d_q      <= 8'h00;
         op_q        <= 2'd0;
         hash_q      <= '0;
         num_q       <= '0;
         rsp_ack_q   <= 1'b0;
         pos_q       <= '0;
         char_q      <= 8'h00;
         char_v_q    <= 1'b0;
      end else begin
         txd_start_q <= tx_go;
         holdoff     <= tx_go;
         if (tx_go) txd_data_q <= tx_byte;
         rx_v_q   <= bus.rxd_data_ready;
         rx_d_q   <= bus.rxd_data;
         char_v_q <= 1'b0;
         if (accept) begin
            op_q      <= bus.cmd_op;
            hash_q    <= bus.cmd_hash;
            num_q     <= bus.cmd_num_bytes;
            rsp_ack_q <= 1'b0;
            pos_q     <= '0;
            char_q    <= 8'h00;
         end
         if (tx_go && state == SEND_HASH)
            hash_q <= {hash_q[119:0], 8'h00};
         if (rx_v_q && state == WAIT_ACK)
            rsp_ack_q <= (rx_d_q == 8'h01);
         if (rx_v_q && state == RX_POS)
            pos_q <= {pos_q[7:0], rx_d_q};
         if (rx_v_q && state == RX_CHARS) begin
            char_q   <= rx_d_q;
            char_v_q <= 1'b1;
            if (cnt == LAST_CHAR) rsp_ack_q <= 1'b1;
         end
         if (tmo_hit) rsp_ack_q <= 1'b0;
      end
   end

   assign bus.txd_start      = txd_start_q;
   assign bus.txd_data       = txd_data_q;
   assign bus.src_ready      = src_ready;
   assign bus.rsp_valid      = (state == DONE);
   assign bus.rsp_ack        = rsp_ack_q;
   assign bus.rsp_byte_pos   = pos_q;
   assign bus.rsp_char       = char_q;
   assign bus.rsp_char_valid = char_v_q;
endmodule

// File: tb/tb_cmd_initiator.sv
// tb_cmd_initiator: directed scoreboard bench for cmd_initiator.
// Expected tx bytes, responses and match chars are queued and checked by a monitor.
module tb_cmd_initiator;
   logic clk_96mhz = 1'b0;
   logic reset     = 1'b1;
   always #5 clk_96mhz = ~clk_96mhz;

   cmd_initiator_if bus();

   cmd_initiator #(
      .MATCH_LEN(19),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk_96mhz(clk_96mhz),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic        ack;
      logic        tmo;
      logic [15:0] pos;
   } rsp_t;

   logic [7:0] exp_tx[$];
   rsp_t       exp_rsp[$];
   logic [7:0] exp_char[$];
   logic [7:0] src_q[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   last_start_cyc = 0;
   int   last_rsp_cyc = 0;
   int   rsp_count = 0;
   int   src_ready_count = 0;
   int   src_gap = 0;
   int   gap_left = 0;
   bit   start_pending = 1'b0;
   bit   src_flush = 1'b0;
   logic uart_busy = 1'b0;
   logic force_busy = 1'b0;
   logic prev_start = 1'b0;
   logic prev_busy = 1'b0;

   assign bus.txd_busy = uart_busy | force_busy;

   always @(posedge clk_96mhz) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_96mhz);
      #1;
   endtask

   // UART tx model: busy rises one cycle after start, lasts 4 cycles
   initial begin
      forever begin
         @(negedge clk_96mhz);
         if (bus.txd_start) begin
            @(posedge clk_96mhz); #1 uart_busy = 1'b1;
            repeat (4) @(posedge clk_96mhz);
            #1 uart_busy = 1'b0;
         end
      end
   end

   // payload source with optional idle gaps between bytes
   initial begin
      bus.src_valid = 1'b0;
      bus.src_data  = 8'h00;
      forever begin
         @(negedge clk_96mhz);
         if (reset || src_flush) begin
            src_q.delete();
            bus.src_valid = 1'b0;
         end else if (bus.src_valid && bus.src_ready) begin
            @(posedge clk_96mhz); #1;
            void'(src_q.pop_front());
            bus.src_valid = 1'b0;
            gap_left = src_gap;
         end else if (!bus.src_valid && src_q.size() != 0) begin
            if (gap_left > 0) gap_left--;
            else begin
               bus.src_data  = src_q[0];
               bus.src_valid = 1'b1;
            end
         end
      end
   end

   // monitor: pops and compares whenever the DUT presents an output
   initial begin
      logic [7:0] e;
      rsp_t r;
      forever begin
         @(negedge clk_96mhz);
         if (!reset) begin
            if (bus.txd_start) begin
               check("tx_back_to_back", prev_start, 0);
               check("tx_while_busy", prev_busy, 0);
               if (exp_tx.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL tx_extra: got byte %0h expected none",
                           bus.txd_data);
               end else begin
                  e = exp_tx.pop_front();
                  check("tx_byte", bus.txd_data, e);
               end
               if (start_pending) begin
                  check("cmd_to_start", cyc - accept_cyc, 2);
                  start_pending = 1'b0;
               end
               last_start_cyc = cyc;
            end
            if (bus.src_ready) src_ready_count++;
            if (bus.rsp_valid) begin
               rsp_count++;
               last_rsp_cyc = cyc;
               if (exp_rsp.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rsp_extra: got rsp_valid expected none");
               end else begin
                  r = exp_rsp.pop_front();
                  check("rsp_ack", bus.rsp_ack, r.ack);
                  check("rsp_timeout", bus.rsp_timeout, r.tmo);
                  check("rsp_byte_pos", bus.rsp_byte_pos, r.pos);
               end
            end
            if (bus.rsp_char_valid) begin
               if (exp_char.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL char_extra: got %0h expected none",
                           bus.rsp_char);
               end else begin
                  e = exp_char.pop_front();
                  check("rsp_char", bus.rsp_char, e);
               end
            end
         end
         prev_start = bus.txd_start;
         prev_busy  = bus.txd_busy;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [127:0] h,
                        input logic [15:0] n);
      bit got;
      got = 1'b0;
      bus.cmd_valid     = 1'b1;
      bus.cmd_op        = op;
      bus.cmd_hash      = h;
      bus.cmd_num_bytes = n;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk_96mhz);
         if (bus.cmd_ready) got = 1'b1;
      end
      check("cmd_accepted", got, 1);
      accept_cyc    = cyc;
      start_pending = (op != 2'd0);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b);
      bus.rxd_data       = b;
      bus.rxd_data_ready = 1'b1;
      tick();
      bus.rxd_data_ready = 1'b0;
      tick(2);
   endtask

   task automatic wait_tx(input string name);
      for (int i = 0; i < 4000 && exp_tx.size() != 0; i++)
         @(negedge clk_96mhz);
      check({name, "_tx_drain"}, exp_tx.size(), 0);
      tick();
   endtask

   task automatic wait_rsp(input string name);
      for (int i = 0; i < 4000 && exp_rsp.size() != 0; i++)
         @(negedge clk_96mhz);
      check({name, "_rsp_drain"}, exp_rsp.size(), 0);
      tick();
   endtask

   task automatic check_reset_vals();
      check("rst_txd_start", bus.txd_start, 0);
      check("rst_txd_data", bus.txd_data, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_src_ready", bus.src_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_ack", bus.rsp_ack, 0);
      check("rst_rsp_timeout", bus.rsp_timeout, 0);
      check("rst_rsp_byte_pos", bus.rsp_byte_pos, 0);
      check("rst_rsp_char", bus.rsp_char, 0);
      check("rst_rsp_char_valid", bus.rsp_char_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      int    d;
      int    base;
      bus.cmd_valid      = 1'b0;
      bus.cmd_op         = 2'd0;
      bus.cmd_hash       = '0;
      bus.cmd_num_bytes  = '0;
      bus.rxd_data       = 8'h00;
      bus.rxd_data_ready = 1'b0;

      tick(3);
      @(negedge clk_96mhz);
      check("cmd_ready_in_reset", bus.cmd_ready, 0);
      @(posedge clk_96mhz); #1 reset = 1'b0;
      @(negedge clk_96mhz);
      check_reset_vals();
      tick();

      // SET with a 50-cycle busy stall, ack 0x01
      exp_tx.push_back(8'h01);
      for (int i = 0; i < 16; i++) exp_tx.push_back(8'(i * 17));
      exp_rsp.push_back('{ack: 1'b1, tmo: 1'b0, pos: 16'h0000});
      issue(2'd1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'd0);
      for (int i = 0; i < 2000 && exp_tx.size() > 10; i++)
         @(negedge clk_96mhz);
      tick();
      force_busy = 1'b1;
      tick(50);
      force_busy = 1'b0;
      wait_tx("set");
      tick(8);
      rx_send(8'h01);
      wait_rsp("set");

      // PROC "abc" with source gaps, one surplus byte left unused
      src_gap = 3;
      src_q = '{8'h61, 8'h62, 8'h63, 8'h7A};
      exp_tx = '{8'h02, 8'h00, 8'h03, 8'h61, 8'h62, 8'h63};
      exp_rsp.push_back('{ack: 1'b0, tmo: 1'b0, pos: 16'h0000});
      issue(2'd2, '0, 16'd3);
      wait_tx("proc3");
      check("proc3_src_left", src_q.size(), 1);
      src_flush = 1'b1;
      tick(2);
      src_flush = 1'b0;
      tick(6);
      rx_send(8'h00);
      wait_rsp("proc3");

      // PROC with zero length: header only, src never ready
      base = src_ready_count;
      exp_tx = '{8'h02, 8'h00, 8'h00};
      exp_rsp.push_back('{ack: 1'b1, tmo: 1'b0, pos: 16'h0000});
      issue(2'd2, '0, 16'd0);
      wait_tx("proc0");
      tick(8);
      check("proc0_src_ready", src_ready_count - base, 0);
      rx_send(8'h01);
      wait_rsp("proc0");

      // invalid op: no bytes, immediate nack
      exp_rsp.push_back('{ack: 1'b0, tmo: 1'b0, pos: 16'h0000});
      issue(2'd0, '0, 16'd0);
      wait_rsp("inv");
      tick(10);

      // RET: position 0x012C then 19 match chars
      s = "The quick brown fox";
      exp_tx.push_back(8'h03);
      exp_rsp.push_back('{ack: 1'b1, tmo: 1'b0, pos: 16'h012C});
      for (int i = 0; i < s.len(); i++) exp_char.push_back(s[i]);
      issue(2'd3, '0, 16'd0);
      wait_tx("ret");
      tick(8);
      rx_send(8'h01);
      rx_send(8'h2C);
      for (int i = 0; i < s.len(); i++) rx_send(s[i]);
      wait_rsp("ret");
      check("ret_chars_left", exp_char.size(), 0);

      // SET with no reply
      exp_tx.push_back(8'h01);
      for (int i = 0; i < 16; i++) exp_tx.push_back(8'hA5);
      base = rsp_count;
`ifdef CMD_INITIATOR_TIMEOUT_EN
      exp_rsp.push_back('{ack: 1'b0, tmo: 1'b1, pos: 16'h0000});
      issue(2'd1, {16{8'hA5}}, 16'd0);
      wait_tx("tmo");
      wait_rsp("tmo");
      d = last_rsp_cyc - last_start_cyc;
      check("tmo_latency_in_window", (d >= 98 && d <= 102), 1);
`else
      issue(2'd1, {16{8'hA5}}, 16'd0);
      wait_tx("notmo");
      tick(1000);
      check("notmo_no_rsp", rsp_count - base, 0);
      exp_rsp.push_back('{ack: 1'b1, tmo: 1'b0, pos: 16'h0000});
      rx_send(8'h01);
      wait_rsp("notmo");
`endif

      // reset in the middle of a PROC payload
      src_gap = 0;
      src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_tx = '{8'h02, 8'h00, 8'h05};
      base = rsp_count;
      issue(2'd2, '0, 16'd5);
      wait_tx("rstproc");
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      @(negedge clk_96mhz);
      check_reset_vals();
      tick(20);
      check("rstproc_no_rsp", rsp_count - base, 0);

      // next command after reset runs normally
      src_q = '{8'h78, 8'h79};
      exp_tx = '{8'h02, 8'h00, 8'h02, 8'h78, 8'h79};
      exp_rsp.push_back('{ack: 1'b1, tmo: 1'b0, pos: 16'h0000});
      issue(2'd2, '0, 16'd2);
      wait_tx("post");
      tick(8);
      rx_send(8'h01);
      wait_rsp("post");

      tick(10);
      check("end_tx_queue", exp_tx.size(), 0);
      check("end_rsp_queue", exp_rsp.size(), 0);
      check("end_char_queue", exp_char.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
